// File: rtl/l1i_cache_pkg.sv
// Shared constants and types for the L1 instruction cache.
// Geometry: direct-mapped, 32 lines of 4 words.
package l1i_cache_pkg;
  localparam int L1I_LINES = 32;
  localparam int L1I_WORDS = 4;
  localparam int IDX_W     = $clog2(L1I_LINES);
  localparam int WORD_W    = $clog2(L1I_WORDS);
  localparam int TAG_W     = 32 - IDX_W - WORD_W - 2;
  localparam int LINE_W    = TAG_W + IDX_W;

  localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    L1I_IDLE      = 2'd0,
    L1I_REFILL    = 2'd1,
    L1I_FILL_DONE = 2'd2
  } l1i_state_e;

  function automatic logic [WORD_W-1:0] last_word();
    return WORD_W'(L1I_WORDS - 1);
  endfunction
endpackage

// File: rtl/l1i_cache_if.sv
// Fetch-side and MMU refill-side signals of the L1I cache.
// The master modport is the cache; slave is the IF stage plus MMU.
interface l1i_cache_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_data_out;
  logic        invalidate;
  logic        mmu_read_enable;
  logic [31:0] mmu_address;
  logic [1:0]  mmu_mem_data_width;
  logic        mmu_mem_signed_read;
  logic        mmu_mem_ready;
  logic [31:0] mmu_data_out;

  modport master (
    input  cpu_req, cpu_addr, invalidate, mmu_mem_ready, mmu_data_out,
    output cpu_ready, cpu_data_out, mmu_read_enable, mmu_address,
           mmu_mem_data_width, mmu_mem_signed_read
  );
  modport slave (
    output cpu_req, cpu_addr, invalidate, mmu_mem_ready, mmu_data_out,
    input  cpu_ready, cpu_data_out, mmu_read_enable, mmu_address,
           mmu_mem_data_width, mmu_mem_signed_read
  );
endinterface

// File: rtl/l1i_data_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
module l1i_data_array #(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/l1i_cache.sv
// Direct-mapped L1 instruction cache: same-cycle hits, 4-word line refill via the MMU.
// Tags, valid bits and the refill FSM live here; words live in l1i_data_array.
module l1i_cache
  import l1i_cache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  l1i_cache_if.master  bus
);
  l1i_state_e           state_q, state_d;
  logic [L1I_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [L1I_LINES];
  logic [TAG_W-1:0]     tag_d [L1I_LINES];
  logic [LINE_W-1:0]    line_q, line_d;
  logic [WORD_W-1:0]    cnt_q, cnt_d;
  logic                 rd_en_q, rd_en_d;
  logic                 pend_q, pend_d;

  logic [IDX_W-1:0]     req_idx, fill_idx;
  logic                 hit, we;
  logic [31:0]          rdata;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^bus.cpu_addr[1:0];
  assign req_idx  = bus.cpu_addr[IDX_W+WORD_W+1:WORD_W+2];
  assign fill_idx = line_q[IDX_W-1:0];
  assign hit = bus.cpu_req && (state_q == L1I_IDLE) && valid_q[req_idx] &&
               (tag_q[req_idx] == bus.cpu_addr[31:32-TAG_W]);
  // Only a word the FSM actually asked for may land in the array.
  assign we  = (state_q == L1I_REFILL) && rd_en_q && bus.mmu_mem_ready;

  l1i_data_array #(.DEPTH(L1I_LINES*L1I_WORDS), .WIDTH(32)) u_data (
    .clk   (clk),
    .we    (we),
    .waddr ({fill_idx, cnt_q}),
    .wdata (bus.mmu_data_out),
    .raddr (bus.cpu_addr[IDX_W+WORD_W+1:2]),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    rd_en_d = rd_en_q;
    pend_d  = pend_q;
    unique case (state_q)
      L1I_IDLE: begin
        if (bus.invalidate) valid_d = '0;
        if (bus.cpu_req && !hit) begin
          line_d  = bus.cpu_addr[31:WORD_W+2];
          cnt_d   = '0;
          rd_en_d = 1'b1;
          state_d = L1I_REFILL;
        end
      end
      L1I_REFILL: begin
        if (bus.invalidate) pend_d = 1'b1;
        // Read enable drops for one cycle after every accepted word.
        if (!rd_en_q) rd_en_d = 1'b1;
        else if (bus.mmu_mem_ready) begin
          rd_en_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == last_word()) begin
            tag_d[fill_idx]   = line_q[LINE_W-1:IDX_W];
            valid_d[fill_idx] = 1'b1;
            state_d           = L1I_FILL_DONE;
          end
        end
      end
      L1I_FILL_DONE: begin
        state_d = L1I_IDLE;
        if (pend_q || bus.invalidate) begin
          valid_d = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = L1I_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= L1I_IDLE;
      valid_q <= '0;
      tag_q   <= '{default: '0};
      line_q  <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.cpu_ready           = hit && !reset;
  assign bus.cpu_data_out        = (hit && !reset) ? rdata : '0;
  assign bus.mmu_read_enable     = rd_en_q && !reset;
  assign bus.mmu_address         = reset ? '0 : {line_q, cnt_q, 2'b00};
  assign bus.mmu_mem_data_width  = MMU_WIDTH_WORD;
  assign bus.mmu_mem_signed_read = 1'b0;
endmodule

// File: tb/tb_l1i_cache.sv
// Scoreboarded bench for l1i_cache with a variable-latency MMU model.
module tb_l1i_cache;
  import l1i_cache_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic cpu_req, invalidate, spur, mdl_rdy;
  logic [31:0] cpu_addr, mdl_data, held;
  int checks = 0, fails = 0;
  int mmu_lat = 1, cnt = 0, reqs = 0;
  bit prev_en = 0, prev_rdy = 0;
  logic [31:0] sb_q[$];
  logic [31:0] addr_q[$];

  l1i_cache_if bus ();
  assign bus.cpu_req       = cpu_req;
  assign bus.cpu_addr      = cpu_addr;
  assign bus.invalidate    = invalidate;
  assign bus.mmu_mem_ready = mdl_rdy | spur;
  assign bus.mmu_data_out  = spur ? 32'hDEAD_BEEF : mdl_data;

  l1i_cache dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {w[15:0], w[31:16]} ^ 32'h5A3C_C3A5;
  endfunction

  // MMU model: answers each request mmu_lat cycles after it appears.
  initial begin
    mdl_rdy = 1'b0;
    mdl_data = '0;
    held = '0;
    forever begin
      @(negedge clk);
      if (prev_rdy) chk("refill_gap", bus.mmu_read_enable, 0);
      prev_rdy = 0;
      mdl_rdy = 1'b0;
      if (bus.mmu_read_enable) begin
        if (!prev_en) reqs++;
        if (cnt == 0) held = bus.mmu_address;
        else chk("addr_hold", bus.mmu_address, held);
        if (cnt == mmu_lat - 1) begin
          chk("req_expected", addr_q.size() > 0, 1);
          if (addr_q.size() > 0) chk("mmu_addr", bus.mmu_address, addr_q.pop_front());
          mdl_rdy = 1'b1;
          mdl_data = mem_word(bus.mmu_address);
          prev_rdy = 1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
      prev_en = bus.mmu_read_enable;
    end
  end

  always @(negedge clk) begin
    if (bus.cpu_ready) begin
      chk("sb_pending", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) chk("cpu_data", bus.cpu_data_out, sb_q.pop_front());
    end
  end

  // Caller sits just after a rising edge; returns just after a rising edge.
  task automatic fetch(input logic [31:0] a, input bit miss);
    int n = 0;
    bit got = 0;
    sb_q.push_back(mem_word(a));
    if (miss) for (int w = 0; w < 4; w++) addr_q.push_back({a[31:4], w[1:0], 2'b00});
    cpu_addr = a;
    cpu_req  = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (bus.cpu_ready) got = 1;
      else n++;
    end
    chk("ready_seen", got, 1);
    chk(miss ? "miss_latency" : "hit_latency", n, miss ? 4*mmu_lat + 5 : 0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    int r, k;
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = '0; invalidate = 1'b0; spur = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_data", bus.cpu_data_out, 0);
    chk("rst_rd_en", bus.mmu_read_enable, 0);
    chk("rst_addr", bus.mmu_address, 0);
    chk("width", bus.mmu_mem_data_width, MMU_WIDTH_WORD);
    chk("signed", bus.mmu_mem_signed_read, 0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0;

    // Cold miss then same-cycle hits on the filled line.
    fetch(32'h0, 1);
    fetch(32'h0, 0);
    r = reqs;
    fetch(32'h4, 0);
    fetch(32'h8, 0);
    fetch(32'hC, 0);
    chk("hit_no_refill", reqs, r);

    // Stray MMU ready in IDLE must not disturb stored words.
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    fetch(32'h8, 0);
    chk("spur_no_refill", reqs, r);

    // Conflict misses on index 1.
    fetch(32'h10, 1);
    fetch(32'h210, 1);
    fetch(32'h10, 1);

    mmu_lat = 3;
    fetch(32'h1234_5670, 1);
    fetch(32'h1234_5674, 0);

    // Invalidate during word-2 read; request dropped and address moved mid-refill.
    for (int w = 0; w < 4; w++) addr_q.push_back(32'h520 + 32'(w*4));
    cpu_addr = 32'h520; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 32'h9990;
    k = 0;
    while (!(bus.mmu_read_enable && bus.mmu_address == 32'h528) && k < 100) begin
      @(negedge clk); k++;
    end
    chk("inv_window", k < 100, 1);
    @(posedge clk); #1 invalidate = 1'b1;
    @(posedge clk); #1 invalidate = 1'b0;
    k = 0;
    while (addr_q.size() > 0 && k < 100) begin @(negedge clk); k++; end
    chk("inv_refill_done", addr_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    fetch(32'h520, 1);
    fetch(32'h1234_5674, 1);

    // IDLE invalidate: same-cycle lookup still hits, next fetch misses.
    fetch(32'h30, 1);
    invalidate = 1'b1;
    fetch(32'h30, 0);
    invalidate = 1'b0;
    fetch(32'h30, 1);

    // Reset in the middle of a refill.
    cpu_addr = 32'h700; cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd_en", bus.mmu_read_enable, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_next_rd_en", bus.mmu_read_enable, 0);
    chk("rst_next_ready", bus.cpu_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    fetch(32'h700, 1);

    repeat (4) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("addr_drained", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
